// File: rtl/r_data_reg_if.sv
// Bus between the router FSM / input source and the datapath register stage.
// The master side drives the byte stream and the FSM strobes; the slave side returns dout and status.
interface r_data_reg_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  pkt_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  fifo_full;
  logic                  detect_add;
  logic                  lfd_state;
  logic                  ld_state;
  logic                  laf_state;
  logic                  full_state;
  logic                  rst_int_reg;
  logic [DATA_WIDTH-1:0] dout;
  logic                  parity_done;
  logic                  low_packet_valid;
  logic                  err;
  logic                  len_err;

  modport master (
    output pkt_valid, data_in, fifo_full,
    output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    input  dout, parity_done, low_packet_valid, err, len_err
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    output dout, parity_done, low_packet_valid, err, len_err
  );
endinterface

// File: rtl/r_data_reg.sv
// Datapath register stage of the 1x4 router: header latch, FIFO-facing dout,
// full-hold byte, running parity, payload count and per-packet error flags.
module r_data_reg #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = DATA_WIDTH - 2
) (
  input  logic         clk,
  input  logic         reset,
  r_data_reg_if.slave  bus
);

  logic [DATA_WIDTH-1:0] header_q, header_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] full_hold_q, full_hold_d;
  logic [DATA_WIDTH-1:0] parity_q, parity_d;
  logic [DATA_WIDTH-1:0] pkt_parity_q, pkt_parity_d;
  logic [LEN_WIDTH-1:0]  count_q, count_d;
  logic                  low_pkt_valid_q, low_pkt_valid_d;
  logic                  parity_done_q, parity_done_d;
  logic                  parity_done_prev_q, parity_done_prev_d;
  logic                  err_q, err_d;
  logic                  len_err_q, len_err_d;

  logic                  acc_ld;
  logic                  acc_laf;
  logic                  laf_parity;
  logic                  check_pulse;
  logic [LEN_WIDTH-1:0]  header_len;

  assign header_len  = header_q[DATA_WIDTH-1:2];
  assign acc_ld      = bus.ld_state && bus.pkt_valid && !bus.full_state && !bus.fifo_full;
  assign acc_laf     = bus.laf_state && !low_pkt_valid_q;
  // When pkt_valid fell under a full FIFO, full_hold carries the parity byte, not payload.
  assign laf_parity  = bus.laf_state && low_pkt_valid_q && !parity_done_q;
  assign check_pulse = parity_done_q && !parity_done_prev_q;

  always_comb begin
    header_d           = header_q;
    dout_d             = dout_q;
    full_hold_d        = full_hold_q;
    parity_d           = parity_q;
    pkt_parity_d       = pkt_parity_q;
    count_d            = count_q;
    low_pkt_valid_d    = low_pkt_valid_q;
    parity_done_d      = parity_done_q;
    parity_done_prev_d = parity_done_q;
    err_d              = err_q;
    len_err_d          = len_err_q;

    if (bus.detect_add && bus.pkt_valid) begin
      header_d = bus.data_in;
    end

    if (bus.lfd_state) begin
      dout_d = header_q;
    end else if (bus.ld_state && !bus.fifo_full) begin
      dout_d = bus.data_in;
    end else if (bus.laf_state) begin
      dout_d = full_hold_q;
    end

    if (bus.ld_state && bus.fifo_full) begin
      full_hold_d = bus.data_in;
    end

    if (bus.detect_add) begin
      parity_d = '0;
      count_d  = '0;
    end else if (bus.lfd_state) begin
      parity_d = parity_q ^ header_q;
    end else if (acc_ld) begin
      parity_d = parity_q ^ bus.data_in;
      count_d  = count_q + LEN_WIDTH'(1);
    end else if (acc_laf) begin
      parity_d = parity_q ^ full_hold_q;
      count_d  = count_q + LEN_WIDTH'(1);
    end

    if (bus.ld_state && !bus.pkt_valid && !bus.fifo_full) begin
      pkt_parity_d = bus.data_in;
    end else if (laf_parity) begin
      pkt_parity_d = full_hold_q;
    end

    // detect_add clears first; a set beats rst_int_reg when both arrive together.
    if (bus.detect_add) begin
      low_pkt_valid_d = 1'b0;
    end else if (bus.ld_state && !bus.pkt_valid && bus.fifo_full) begin
      low_pkt_valid_d = 1'b1;
    end else if (bus.rst_int_reg) begin
      low_pkt_valid_d = 1'b0;
    end

    if (bus.detect_add) begin
      parity_done_d = 1'b0;
    end else if ((bus.ld_state && !bus.pkt_valid && !bus.fifo_full) || laf_parity) begin
      parity_done_d = 1'b1;
    end

    if (bus.detect_add) begin
      err_d     = 1'b0;
      len_err_d = 1'b0;
    end else if (check_pulse) begin
      err_d     = (parity_q != pkt_parity_q);
      len_err_d = (count_q != header_len);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      header_q           <= '0;
      dout_q             <= '0;
      full_hold_q        <= '0;
      parity_q           <= '0;
      pkt_parity_q       <= '0;
      count_q            <= '0;
      low_pkt_valid_q    <= 1'b0;
      parity_done_q      <= 1'b0;
      parity_done_prev_q <= 1'b0;
      err_q              <= 1'b0;
      len_err_q          <= 1'b0;
    end else begin
      header_q           <= header_d;
      dout_q             <= dout_d;
      full_hold_q        <= full_hold_d;
      parity_q           <= parity_d;
      pkt_parity_q       <= pkt_parity_d;
      count_q            <= count_d;
      low_pkt_valid_q    <= low_pkt_valid_d;
      parity_done_q      <= parity_done_d;
      parity_done_prev_q <= parity_done_prev_d;
      err_q              <= err_d;
      len_err_q          <= len_err_d;
    end
  end

  assign bus.dout             = dout_q;
  assign bus.parity_done      = parity_done_q;
  assign bus.low_packet_valid = low_pkt_valid_q;
  assign bus.err              = err_q;
  assign bus.len_err          = len_err_q;

endmodule

// File: tb/tb_r_data_reg.sv
// Scoreboard bench for r_data_reg: directed packets push expected outputs,
// a negedge monitor pops and compares them once the DUT has clocked the cycle.
module tb_r_data_reg;

  localparam int DW = 8;

  typedef enum int {S_IDLE, S_DA, S_LFD, S_LD, S_LAF, S_FULL, S_CPE} st_t;

  typedef struct {
    string      name;
    int         due;
    logic [7:0] dout;
    logic       pd;
    logic       lpv;
    logic       err;
    logic       len;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cycle_cnt = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  r_data_reg_if #(.DATA_WIDTH(DW)) bus ();

  r_data_reg #(.DATA_WIDTH(DW), .LEN_WIDTH(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always @(posedge clk) cycle_cnt++;

  task automatic checkOutput(input string nm, input logic [7:0] e_dout, input logic e_pd,
                             input logic e_lpv, input logic e_err, input logic e_len);
    checks++;
    if (bus.dout === e_dout && bus.parity_done === e_pd && bus.low_packet_valid === e_lpv &&
        bus.err === e_err && bus.len_err === e_len) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got dout=%h pd=%b lpv=%b err=%b len_err=%b, want dout=%h pd=%b lpv=%b err=%b len_err=%b",
               nm, bus.dout, bus.parity_done, bus.low_packet_valid, bus.err, bus.len_err,
               e_dout, e_pd, e_lpv, e_err, e_len);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].due <= cycle_cnt) begin
      e = sb_q.pop_front();
      checkOutput(e.name, e.dout, e.pd, e.lpv, e.err, e.len);
    end
  end

  task automatic setInputs(input st_t st, input logic pv, input logic [7:0] din, input logic ff);
    bus.detect_add  = (st == S_DA);
    bus.lfd_state   = (st == S_LFD);
    bus.ld_state    = (st == S_LD);
    bus.laf_state   = (st == S_LAF);
    bus.full_state  = (st == S_FULL);
    bus.rst_int_reg = (st == S_CPE);
    bus.pkt_valid   = pv;
    bus.data_in     = din;
    bus.fifo_full   = ff;
  endtask

  task automatic applyStimulus(input string nm, input st_t st, input logic pv, input logic [7:0] din,
                               input logic ff, input logic [7:0] e_dout, input logic e_pd,
                               input logic e_lpv, input logic e_err, input logic e_len);
    exp_t e;
    setInputs(st, pv, din, ff);
    e.name = nm;
    e.due  = cycle_cnt + 1;
    e.dout = e_dout;
    e.pd   = e_pd;
    e.lpv  = e_lpv;
    e.err  = e_err;
    e.len  = e_len;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Clean packet 0D A1 52 3C / C2; dout_prev is what dout holds before the header cycle.
  task automatic cleanPacket(input string tag, input logic [7:0] dout_prev);
    applyStimulus({tag, " hdr"}, S_DA,  1, 8'h0D, 0, dout_prev, 0, 0, 0, 0);
    applyStimulus({tag, " lfd"}, S_LFD, 1, 8'hA1, 0, 8'h0D, 0, 0, 0, 0);
    applyStimulus({tag, " d0"},  S_LD,  1, 8'hA1, 0, 8'hA1, 0, 0, 0, 0);
    applyStimulus({tag, " d1"},  S_LD,  1, 8'h52, 0, 8'h52, 0, 0, 0, 0);
    applyStimulus({tag, " d2"},  S_LD,  1, 8'h3C, 0, 8'h3C, 0, 0, 0, 0);
    applyStimulus({tag, " par"}, S_LD,  0, 8'hC2, 0, 8'hC2, 1, 0, 0, 0);
    applyStimulus({tag, " chk"}, S_CPE, 0, 8'h00, 0, 8'hC2, 1, 0, 0, 0);
    applyStimulus({tag, " idl"}, S_IDLE,0, 8'h00, 0, 8'hC2, 1, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    setInputs(S_IDLE, 0, 8'h00, 0);
    #12;
    checkOutput("reset state", 8'h00, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus("post reset idle", S_IDLE, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);

    cleanPacket("clean", 8'h00);

    applyStimulus("badpar hdr", S_DA,  1, 8'h0D, 0, 8'hC2, 0, 0, 0, 0);
    applyStimulus("badpar lfd", S_LFD, 1, 8'hA1, 0, 8'h0D, 0, 0, 0, 0);
    applyStimulus("badpar d0",  S_LD,  1, 8'hA1, 0, 8'hA1, 0, 0, 0, 0);
    applyStimulus("badpar d1",  S_LD,  1, 8'h52, 0, 8'h52, 0, 0, 0, 0);
    applyStimulus("badpar d2",  S_LD,  1, 8'h3C, 0, 8'h3C, 0, 0, 0, 0);
    applyStimulus("badpar par", S_LD,  0, 8'hC3, 0, 8'hC3, 1, 0, 0, 0);
    applyStimulus("badpar chk", S_CPE, 0, 8'h00, 0, 8'hC3, 1, 0, 1, 0);
    applyStimulus("badpar hold",S_IDLE,0, 8'h00, 0, 8'hC3, 1, 0, 1, 0);

    applyStimulus("full hdr",   S_DA,  1, 8'h0D, 0, 8'hC3, 0, 0, 0, 0);
    applyStimulus("full lfd",   S_LFD, 1, 8'hA1, 0, 8'h0D, 0, 0, 0, 0);
    applyStimulus("full d0",    S_LD,  1, 8'hA1, 0, 8'hA1, 0, 0, 0, 0);
    applyStimulus("full d1",    S_LD,  1, 8'h52, 1, 8'hA1, 0, 0, 0, 0);
    applyStimulus("full wait0", S_FULL,1, 8'h52, 1, 8'hA1, 0, 0, 0, 0);
    applyStimulus("full wait1", S_FULL,1, 8'h52, 0, 8'hA1, 0, 0, 0, 0);
    applyStimulus("full laf",   S_LAF, 1, 8'h3C, 0, 8'h52, 0, 0, 0, 0);
    applyStimulus("full d2",    S_LD,  1, 8'h3C, 0, 8'h3C, 0, 0, 0, 0);
    applyStimulus("full par",   S_LD,  0, 8'hC2, 0, 8'hC2, 1, 0, 0, 0);
    applyStimulus("full chk",   S_CPE, 0, 8'h00, 0, 8'hC2, 1, 0, 0, 0);

    applyStimulus("lpv hdr",    S_DA,  1, 8'h0D, 0, 8'hC2, 0, 0, 0, 0);
    applyStimulus("lpv lfd",    S_LFD, 1, 8'hA1, 0, 8'h0D, 0, 0, 0, 0);
    applyStimulus("lpv d0",     S_LD,  1, 8'hA1, 0, 8'hA1, 0, 0, 0, 0);
    applyStimulus("lpv d1",     S_LD,  1, 8'h52, 0, 8'h52, 0, 0, 0, 0);
    applyStimulus("lpv d2",     S_LD,  1, 8'h3C, 0, 8'h3C, 0, 0, 0, 0);
    applyStimulus("lpv par",    S_LD,  0, 8'hC2, 1, 8'h3C, 0, 1, 0, 0);
    applyStimulus("lpv wait0",  S_FULL,0, 8'h00, 1, 8'h3C, 0, 1, 0, 0);
    applyStimulus("lpv wait1",  S_FULL,0, 8'h00, 0, 8'h3C, 0, 1, 0, 0);
    applyStimulus("lpv laf",    S_LAF, 0, 8'h00, 0, 8'hC2, 1, 1, 0, 0);
    applyStimulus("lpv chk",    S_CPE, 0, 8'h00, 0, 8'hC2, 1, 0, 0, 0);

    applyStimulus("len hdr",    S_DA,  1, 8'h11, 0, 8'hC2, 0, 0, 0, 0);
    applyStimulus("len lfd",    S_LFD, 1, 8'hA1, 0, 8'h11, 0, 0, 0, 0);
    applyStimulus("len d0",     S_LD,  1, 8'hA1, 0, 8'hA1, 0, 0, 0, 0);
    applyStimulus("len d1",     S_LD,  1, 8'h52, 0, 8'h52, 0, 0, 0, 0);
    applyStimulus("len d2",     S_LD,  1, 8'h3C, 0, 8'h3C, 0, 0, 0, 0);
    applyStimulus("len par",    S_LD,  0, 8'hDE, 0, 8'hDE, 1, 0, 0, 0);
    applyStimulus("len chk",    S_CPE, 0, 8'h00, 0, 8'hDE, 1, 0, 0, 1);
    applyStimulus("len hold",   S_IDLE,0, 8'h00, 0, 8'hDE, 1, 0, 0, 1);

    applyStimulus("arst hdr",   S_DA,  1, 8'h0D, 0, 8'hDE, 0, 0, 0, 0);
    applyStimulus("arst lfd",   S_LFD, 1, 8'hA1, 0, 8'h0D, 0, 0, 0, 0);
    applyStimulus("arst d0",    S_LD,  1, 8'hA1, 0, 8'hA1, 0, 0, 0, 0);
    applyStimulus("arst d1",    S_LD,  1, 8'h52, 0, 8'h52, 0, 0, 0, 0);
    setInputs(S_IDLE, 0, 8'h00, 0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async reset", 8'h00, 0, 0, 0, 0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus("arst idle",  S_IDLE,0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    cleanPacket("after arst", 8'h00);

    applyStimulus("zero hdr",   S_DA,  1, 8'h02, 0, 8'hC2, 0, 0, 0, 0);
    applyStimulus("zero lfd",   S_LFD, 0, 8'h02, 0, 8'h02, 0, 0, 0, 0);
    applyStimulus("zero par",   S_LD,  0, 8'h02, 0, 8'h02, 1, 0, 0, 0);
    applyStimulus("zero chk",   S_CPE, 0, 8'h00, 0, 8'h02, 1, 0, 0, 0);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      checks++;
      $display("[TB] FAIL drain: got %0d pending expectations, want 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/r_data_reg.md
Name: r_data_reg

Overview:
- Datapath register stage of the 1x4 router, directly downstream of the router FSM.
- Consumes the FSM state strobes (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg) and the input byte stream.
- Latches the header, drives dout toward the four output FIFOs, holds the byte that arrives while the FIFO is full, and accumulates the running parity.
- Produces parity_done, low_packet_valid, err and len_err, which feed back to the FSM and to status.

Parameters:
- DATA_WIDTH, 8, width of data_in/dout; header[1:0] is the destination address, header[DATA_WIDTH-1:2] is the payload length.
- LEN_WIDTH, 6, payload length field and counter width (DATA_WIDTH-2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pkt_valid  in  1  source marks header/payload bytes valid; deasserted on the parity byte.
- data_in  in  DATA_WIDTH  input byte stream.
- fifo_full  in  1  full flag of the selected destination FIFO.
- detect_add  in  1  FSM in DECODE_ADDRESS.
- lfd_state  in  1  FSM in LOAD_FIRST_DATA.
- ld_state  in  1  FSM in LOAD_DATA.
- laf_state  in  1  FSM in LOAD_AFTER_FULL.
- full_state  in  1  FSM in FIFO_FULL_STATE.
- rst_int_reg  in  1  FSM in CHECK_PARITY_ERROR.
- dout  out  DATA_WIDTH  byte to the FIFO write port.
- parity_done  out  1  parity byte captured.
- low_packet_valid  out  1  pkt_valid fell while the FIFO was full.
- err  out  1  parity mismatch, sticky per packet.
- len_err  out  1  payload count differs from the header length, sticky per packet.

Behaviour:
- Reset: every register and output is 0, asynchronously. Assertion mid-packet aborts the packet; after release the block waits for detect_add.
- All outputs are registered. Each update below takes effect on the clk edge after its condition is sampled.
- Header register:
  - Loads data_in when detect_add && pkt_valid.
  - Otherwise holds its value.
- dout, priority high to low:
  1. lfd_state: dout <= header.
  2. ld_state && !fifo_full: dout <= data_in.
  3. laf_state: dout <= full_hold.
  4. Otherwise hold.
- full_hold: loads data_in when ld_state && fifo_full, so the byte presented on the cycle the FIFO fills is not lost.
- Internal parity (XOR, DATA_WIDTH bits):
  - Cleared on detect_add.
  - lfd_state: parity ^= header.
  - ld_state && pkt_valid && !full_state && !fifo_full: parity ^= data_in.
  - laf_state && !low_packet_valid: parity ^= full_hold.
- Payload counter (LEN_WIDTH): cleared on detect_add; increments on every parity-accumulate event except the lfd_state header event. Wraps modulo 2^LEN_WIDTH.
- Packet parity register: loads data_in when ld_state && !pkt_valid && !fifo_full.
  - If pkt_valid falls while fifo_full is high, the parity byte is in full_hold and is loaded from there in laf_state.
- low_packet_valid:
  - Set when ld_state && !pkt_valid && fifo_full.
  - Cleared on rst_int_reg or detect_add.
- parity_done:
  - Set when ld_state && !pkt_valid && !fifo_full.
  - Also set when laf_state && low_packet_valid && !parity_done.
  - Cleared on detect_add.
- err and len_err:
  - A one-cycle check pulse fires on the cycle after parity_done first rises.
  - On that pulse: err <= (parity != packet_parity); len_err <= (count != header[DATA_WIDTH-1:2]).
  - Both hold until detect_add.
- Simultaneous events: detect_add clearing has priority over every set condition. If rst_int_reg && ld_state, the set wins.
- Zero-length header (length 0): the first ld_state byte with !pkt_valid is the parity byte; count stays 0, so len_err = 0.

Test Plan:
- Clean packet: header 8'h0D, payload A1, 52, 3C, parity C2, fifo_full = 0 → dout sequence 0D, A1, 52, 3C, C2; parity_done rises one cycle after the C2 byte; err = 0; len_err = 0.
- Bad parity: same packet with parity byte 8'hC3 → err = 1 the cycle after parity_done; err remains 1 until the next detect_add, then 0.
- FIFO full mid-payload: fifo_full = 1 while 8'h52 is presented in ld_state → dout holds A1. After fifo_full drops and laf_state occurs, dout = 52 and the final parity still matches (err = 0).
- pkt_valid falls while full: fifo_full = 1 when the parity byte C2 arrives → low_packet_valid = 1, parity_done = 0. In laf_state, parity_done = 1, packet parity = C2, err = 0. rst_int_reg clears low_packet_valid.
- Length mismatch: header 8'h11 (length 4, addr 01) with 3 payload bytes → len_err = 1, err = 0 when the parity is correct.
- Async reset mid-payload: reset pulses between clk edges after byte 52 → dout, parity_done, err, len_err and low_packet_valid are 0 immediately. A following clean packet passes with err = 0.
